ring_freq_meter: RTL and testbench

Parametrised multi-channel frequency meter for on-die ring oscillators, the next generation of the single-ring tap-and-count block. Up to N_CH free-running oscillator outputs enter as asynchronous data. One channel is selected and synchronised into `clk`. Its rising edges are counted over a programmable power-of-two gate window. The result is latched with a saturation flag for readout over the dedicated outputs.

---
 rtl/ring_freq_meter.sv | 134 +++++++++++++
 tb/tb_ring_freq_meter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ring_freq_meter.sv
// Multi-channel ring oscillator frequency meter: counts rising edges of one synchronised channel over a power-of-two gate window.
// Optional RING_FREQ_METER_CONTINUOUS_EN: DONE with start held goes straight back to GATE for back-to-back windows.
module ring_freq_meter #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2,
  parameter int GATE_SEL_W    = 3,
  parameter int MIN_GATE_LOG2 = 6,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       osc_in,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic [GATE_SEL_W-1:0] gate_sel,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow
);

  localparam int GC_W = MIN_GATE_LOG2 + (1 << GATE_SEL_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] GATE   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]             state;
  logic [CH_W-1:0]        ch_q;
  logic [CH_W-1:0]        ch_clamp;
  logic [GATE_SEL_W-1:0]  gate_q;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [GC_W-1:0]        gate_cnt;
  logic [GC_W-1:0]        gate_last;
  logic [CNT_W-1:0]       edge_cnt;
  logic [CNT_W-1:0]       edge_cnt_nxt;
  logic                   ovf_q;
  logic                   ovf_nxt;
  logic                   rise;
  logic                   settle_end;
  logic                   gate_end;

  assign ch_clamp   = (32'(ch_sel) >= N_CH) ? CH_W'(N_CH - 1) : ch_sel;
  assign rise       = sync[SYNC_STAGES-1] & ~prev;
  assign gate_last  = (GC_W'(1) << (32'(gate_q) + MIN_GATE_LOG2)) - GC_W'(1);
  // SETTLE covers the synchroniser plus the edge-detect register.
  assign settle_end = (gate_cnt == GC_W'(SYNC_STAGES));
  assign gate_end   = (gate_cnt == gate_last);
  assign busy       = (state == SETTLE) || (state == GATE);
  assign done       = (state == DONE);

  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_q;
    if (state == GATE && rise) begin
      if (&edge_cnt) ovf_nxt = 1'b1;
      else           edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

  // Synchroniser and edge-detect run continuously so they are primed when GATE opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc_in[ch_q]};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ch_q     <= '0;
      gate_q   <= '0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_q    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (!start) begin
            state <= IDLE;
          end else begin
`ifdef RING_FREQ_METER_CONTINUOUS_EN
            if (state == DONE) begin
              state <= GATE;
            end else begin
              ch_q   <= ch_clamp;
              gate_q <= gate_sel;
              state  <= SETTLE;
            end
`else
            ch_q   <= ch_clamp;
            gate_q <= gate_sel;
            state  <= SETTLE;
`endif
          end
          gate_cnt <= '0;
        end
        SETTLE: begin
          if (settle_end) begin
            gate_cnt <= '0;
            state    <= GATE;
          end else begin
            gate_cnt <= gate_cnt + GC_W'(1);
          end
        end
        GATE: begin
          if (gate_end) begin
            count    <= edge_cnt_nxt;
            overflow <= ovf_nxt;
            edge_cnt <= '0;
            ovf_q    <= 1'b0;
            gate_cnt <= '0;
            state    <= DONE;
          end else begin
            edge_cnt <= edge_cnt_nxt;
            ovf_q    <= ovf_nxt;
            gate_cnt <= gate_cnt + GC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter: table of measurements plus restart, reset-abort and start-held sequences.
module tb_ring_freq_meter;

  logic       clk;
  logic       rst_n;
  logic [3:0] osc_in;
  logic [1:0] ch_sel;
  logic [2:0] gate_sel;
  logic       start;
  logic       busy, done, overflow;
  logic [15:0] count;
  logic       s_busy, s_done, s_overflow;
  logic [3:0] s_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ocyc  = 0;

  ring_freq_meter dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .ch_sel(ch_sel), .gate_sel(gate_sel),
    .start(start), .busy(busy), .done(done), .count(count), .overflow(overflow)
  );

  ring_freq_meter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .ch_sel(ch_sel), .gate_sel(gate_sel),
    .start(start), .busy(s_busy), .done(s_done), .count(s_count), .overflow(s_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ch0 stuck high, ch1 period 10, ch2 period 4, ch3 stuck low
  initial begin
    osc_in = 4'b0001;
    forever begin
      @(negedge clk);
      ocyc++;
      osc_in[1] = ((ocyc % 10) < 5);
      osc_in[2] = (((ocyc / 2) % 2) == 1);
    end
  end

  task automatic chk(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic kick(input int ch, input int gs);
    @(posedge clk); #1;
    ch_sel = 2'(ch); gate_sel = 3'(gs); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    int ch; int gs; int lat;
    int lo; int hi; int ovf;
    int slo; int shi; int sovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int lat;
    int t;
    int pulses[3];
    int np;
    int exp_p[3];

    tbl[0] = '{1, 0,  67,  6,  7, 0,  6,  7, 0};
    tbl[1] = '{3, 0,  67,  0,  0, 0,  0,  0, 0};
    tbl[2] = '{2, 0,  67, 16, 16, 0, 15, 15, 1};
    tbl[3] = '{0, 0,  67,  0,  0, 0,  0,  0, 0};
    tbl[4] = '{2, 1, 131, 32, 32, 0, 15, 15, 1};
    tbl[5] = '{1, 1, 131, 12, 13, 0, 12, 13, 0};

    rst_n = 1'b0; start = 1'b0; ch_sel = '0; gate_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_done", int'(done), 0, 0);
    chk("rst_count", int'(count), 0, 0);
    chk("rst_overflow", int'(overflow), 0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      kick(tbl[i].ch, tbl[i].gs);
      chk($sformatf("v%0d_busy", i), int'(busy), 1, 1);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat, tbl[i].lat);
      chk($sformatf("v%0d_busy_in_done", i), int'(busy), 0, 0);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].lo, tbl[i].hi);
      chk($sformatf("v%0d_overflow", i), int'(overflow), tbl[i].ovf, tbl[i].ovf);
      chk($sformatf("v%0d_sat_done", i), int'(s_done), 1, 1);
      chk($sformatf("v%0d_sat_count", i), int'(s_count), tbl[i].slo, tbl[i].shi);
      chk($sformatf("v%0d_sat_overflow", i), int'(s_overflow), tbl[i].sovf, tbl[i].sovf);
      @(posedge clk); #1;
      chk($sformatf("v%0d_count_hold", i), int'(count), tbl[i].lo, tbl[i].hi);
    end

    // start re-pulsed and ch_sel switched to the stuck-high channel mid-GATE
    kick(2, 0);
    repeat (19) @(posedge clk);
    #1;
    ch_sel = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 20;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("restart_latency", lat, 67, 67);
    chk("restart_count", int'(count), 16, 16);

    // reset asserted 30 cycles into GATE
    @(posedge clk);
    kick(1, 0);
    repeat (32) @(posedge clk);
    #1;
    chk("pre_abort_busy", int'(busy), 1, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_done", int'(done), 0, 0);
    chk("abort_count", int'(count), 0, 0);
    chk("abort_overflow", int'(overflow), 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    kick(2, 0);
    wait_done(lat);
    chk("post_abort_latency", lat, 67, 67);
    chk("post_abort_count", int'(count), 16, 16);

    // start held high across several windows
`ifdef RING_FREQ_METER_CONTINUOUS_EN
    exp_p = '{67, 132, 197};
`else
    exp_p = '{67, 135, 203};
`endif
    repeat (3) @(posedge clk);
    #1;
    ch_sel = 2'd2; gate_sel = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    t = 0; np = 0;
    while (np < 3 && t < 400) begin
      @(posedge clk); #1;
      t++;
      if (done) begin
        pulses[np] = t;
        np++;
      end
    end
    start = 1'b0;
    chk("held_pulse_count", np, 3, 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("held_pulse%0d_time", k), (k < np) ? pulses[k] : -1, exp_p[k], exp_p[k]);
    chk("held_last_count", int'(count), 16, 16);
    @(posedge clk); #1;
    chk("held_release_idle_busy", int'(busy), 0, 0);
    chk("held_release_idle_done", int'(done), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
